// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch stage.
package fetch_pkg;

  localparam int unsigned FetchXlen = 32;

  // Opcode steered to the LAA accelerator by decode
  localparam logic [6:0] CustomOpcDefault = 7'b0001011;

  localparam logic [FetchXlen-1:0] ResetPcDefault = 32'h0;

  typedef struct packed {
    logic [FetchXlen-1:0] pc;
    logic [31:0]          ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instructions; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  entry_t                push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output entry_t                head_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  typedef logic [AddrW:0] cnt_t;

  entry_t           mem_q [Depth];
  logic [AddrW-1:0] wr_q, wr_d, rd_q, rd_d;
  cnt_t             cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i && (cnt_q != cnt_t'(Depth));
  assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

  // Pointer and count next-state; flush empties the queue outright
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AddrW'(1);
      if (do_pop)  rd_d = rd_q + AddrW'(1);
      cnt_d = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful while counted
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: req/gnt/rvalid imem handshake, QDEPTH-entry queue,
// redirect with in-flight squashing, custom-opcode flagging.
// Optional PROG_PORT_EN adds the prog/prog_addr programming-mode ports.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(ResetPcDefault),
  parameter logic [6:0]      CUSTOM_OPC = CustomOpcDefault
`ifdef PROG_PORT_EN
  , parameter int unsigned   PROG_AW    = 10
`endif
) (
  input  logic               clk,
  input  logic               Rst_n,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               ins_valid,
  output logic [31:0]        ins,
  output logic [XLEN-1:0]    ins_pc,
  output logic               ins_custom,
  input  logic               ins_ready,
  input  logic               cust_busy,
`ifdef PROG_PORT_EN
  input  logic               prog,
  input  logic [PROG_AW-1:0] prog_addr,
`endif
  output logic               fetch_misalign
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;
  typedef logic [CntW-1:0] cnt_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
  } entry_t;

  logic            prog_w;
  logic [XLEN-1:0] pc_q, pc_d, rpc_q, rpc_d;
  cnt_t            out_q, out_d, drop_q, drop_d, occ;
  logic            misalign_q, misalign_d;
  logic            issue, fire, push, pop, flush, q_valid;
  logic [CntW:0]   inflight;
  entry_t          head, push_entry;

`ifdef PROG_PORT_EN
  assign prog_w    = prog;
  assign imem_addr = prog ? XLEN'({prog_addr, 2'b00}) : pc_q;
`else
  assign prog_w    = 1'b0;
  assign imem_addr = pc_q;
`endif

  // Queued plus in-flight can never exceed the queue, so a push never overflows
  assign inflight = {1'b0, occ} + {1'b0, out_q};
  assign issue    = !prog_w && !misalign_q && !redirect && (inflight < (CntW + 1)'(QDEPTH));
  assign fire     = issue && imem_gnt;
  assign imem_req = Rst_n && (prog_w || issue);

  assign flush      = redirect || prog_w;
  assign pop        = q_valid && ins_ready && !(ins_custom && cust_busy) && !redirect;
  assign push_entry = '{pc: rpc_q, ins: imem_rdata};

  // Next-state for outstanding/drop counters, fetch PC, response PC and misalign flag
  always_comb begin
    out_d      = out_q + cnt_t'(fire) - cnt_t'(imem_rvalid && (out_q != '0));
    drop_d     = drop_q;
    push       = 1'b0;
    pc_d       = pc_q;
    rpc_d      = rpc_q;
    misalign_d = misalign_q;
    // Everything still in flight after this cycle belongs to the discarded stream
    if (flush) begin
      drop_d = out_d;
    end else if (imem_rvalid) begin
      if (drop_q != '0) drop_d = drop_q - cnt_t'(1);
      else              push   = 1'b1;
    end
    if (fire) pc_d  = pc_q + XLEN'(4);
    if (push) rpc_d = rpc_q + XLEN'(4);
    if (redirect) begin
      pc_d       = redirect_pc;
      rpc_d      = redirect_pc;
      misalign_d = (redirect_pc[1:0] != 2'b00);
    end
    // Held at RESET_PC while programming so fetch restarts there when prog drops
    if (prog_w) begin
      pc_d  = RESET_PC;
      rpc_d = RESET_PC;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      pc_q       <= RESET_PC;
      rpc_q      <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rpc_q      <= rpc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_queue #(
    .Depth   (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk_i       (clk),
    .rst_ni      (Rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .valid_o     (q_valid),
    .head_o      (head),
    .count_o     (occ)
  );

  assign ins_valid      = q_valid;
  assign ins            = q_valid ? head.ins : '0;
  assign ins_pc         = q_valid ? head.pc : '0;
  assign ins_custom     = q_valid && (head.ins[6:0] == CUSTOM_OPC);
  assign fetch_misalign = misalign_q;

  // A response with nothing outstanding means memory and fetch disagree
  assert property (@(posedge clk) disable iff (!Rst_n)
                   (imem_rvalid && !prog_w) |-> (out_q != '0));

endmodule
